// File: rtl/div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : div_clk_monitor
// Purpose  : Measures the period of an asynchronous divided clock (c0) in
//            inclk0 cycles. Reports lock on a stable period and a sticky
//            fault when c0 stops. Define DIV_MON_DUTY_EN to add a high-time
//            measurement and a duty check.
// Revision : 1.0 - initial release
// ============================================================================
module div_clk_monitor #(
    parameter int EXP_PERIOD    = 128,
    parameter int TOL           = 4,
    parameter int LOCK_CNT      = 4,
    parameter int FAULT_TIMEOUT = 1024
) (
    input  logic        inclk0,
    input  logic        reset_n,
    input  logic        c0,
    input  logic        enable,
    output logic        rise_tick,
    output logic [15:0] period_count,
    output logic        period_valid,
    output logic        locked,
    output logic        fault
`ifdef DIV_MON_DUTY_EN
    ,
    output logic [15:0] high_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    localparam logic [15:0] c_timeout_last = 16'(FAULT_TIMEOUT - 1);
    localparam logic [3:0]  c_lock_cnt     = 4'(LOCK_CNT);
    localparam logic [17:0] c_exp          = 18'(EXP_PERIOD);
    localparam logic [17:0] c_tol          = 18'(TOL);

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_hist;
    logic [15:0] r_counter;
    logic [3:0]  r_good;

    logic        w_edge;
    logic [15:0] w_meas;
    logic [17:0] w_meas_ext;
    logic [17:0] w_pdev;
    logic        w_in_tol;
    logic [3:0]  w_good_inc;

    assign w_edge     = r_sync2 & ~r_hist;
    // Period includes the rise_tick cycle itself, hence counter + 1.
    assign w_meas     = (r_counter == 16'hFFFF) ? r_counter : r_counter + 16'd1;
    assign w_meas_ext = {2'b00, w_meas};
    assign w_pdev     = (w_meas_ext >= c_exp) ? (w_meas_ext - c_exp) : (c_exp - w_meas_ext);
    assign w_good_inc = (r_good == c_lock_cnt) ? r_good : r_good + 4'd1;

`ifdef DIV_MON_DUTY_EN
    localparam logic [17:0] c_tol2 = 18'(2 * TOL);

    logic [15:0] r_high_acc;
    logic [17:0] w_high2;
    logic [17:0] w_ddev;

    assign w_high2  = {1'b0, r_high_acc, 1'b0};
    assign w_ddev   = (w_high2 >= w_meas_ext) ? (w_high2 - w_meas_ext) : (w_meas_ext - w_high2);
    assign w_in_tol = (w_pdev <= c_tol) && (w_ddev <= c_tol2);

    // High-time accumulator is aligned to the rise_tick window: the rise_tick
    // cycle opens a new period and is itself a high cycle.
    always_ff @(posedge inclk0) begin
        if (!reset_n) begin
            r_high_acc <= 16'd0;
            high_count <= 16'd0;
        end else if (rise_tick) begin
            r_high_acc <= {15'd0, r_hist};
            if (enable && (r_state == S_MEASURE)) begin
                high_count <= r_high_acc;
            end
        end else if (r_hist && (r_high_acc != 16'hFFFF)) begin
            r_high_acc <= r_high_acc + 16'd1;
        end
    end
`else
    assign w_in_tol = (w_pdev <= c_tol);
`endif

    always_ff @(posedge inclk0) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_hist       <= 1'b0;
            r_counter    <= 16'd0;
            r_good       <= 4'd0;
            rise_tick    <= 1'b0;
            period_count <= 16'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            r_sync1      <= c0;
            r_sync2      <= r_sync1;
            r_hist       <= r_sync2;
            rise_tick    <= w_edge;
            period_valid <= 1'b0;
            if (!enable) begin
                r_state   <= S_IDLE;
                r_counter <= 16'd0;
                r_good    <= 4'd0;
                locked    <= 1'b0;
                fault     <= 1'b0;
            end else begin
                locked <= (r_good == c_lock_cnt);
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_ARM;
                        r_counter <= 16'd0;
                    end
                    S_ARM: begin
                        if (rise_tick) begin
                            r_state   <= S_MEASURE;
                            r_counter <= 16'd0;
                        end
                    end
                    S_MEASURE: begin
                        // A rise_tick coinciding with the timeout still counts as a period.
                        if (rise_tick) begin
                            r_counter    <= 16'd0;
                            period_count <= w_meas;
                            period_valid <= 1'b1;
                            r_good       <= w_in_tol ? w_good_inc : 4'd0;
                        end else if (r_counter == c_timeout_last) begin
                            r_state   <= S_ARM;
                            r_counter <= 16'd0;
                            r_good    <= 4'd0;
                            locked    <= 1'b0;
                            fault     <= 1'b1;
                        end else begin
                            r_counter <= w_meas;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_clk_monitor
// Purpose  : Randomised self-checking bench for div_clk_monitor against a
//            cycle-number based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_clk_monitor;

    localparam int EXP_PERIOD    = 128;
    localparam int TOL           = 4;
    localparam int LOCK_CNT      = 4;
    localparam int FAULT_TIMEOUT = 1024;

    logic        inclk0  = 1'b0;
    logic        reset_n = 1'b0;
    logic        c0      = 1'b0;
    logic        enable  = 1'b0;
    logic        rise_tick;
    logic [15:0] period_count;
    logic        period_valid;
    logic        locked;
    logic        fault;
`ifdef DIV_MON_DUTY_EN
    logic [15:0] high_count;
`endif

    div_clk_monitor #(
        .EXP_PERIOD   (EXP_PERIOD),
        .TOL          (TOL),
        .LOCK_CNT     (LOCK_CNT),
        .FAULT_TIMEOUT(FAULT_TIMEOUT)
    ) u_dut (
        .inclk0      (inclk0),
        .reset_n     (reset_n),
        .c0          (c0),
        .enable      (enable),
        .rise_tick   (rise_tick),
        .period_count(period_count),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault)
`ifdef DIV_MON_DUTY_EN
        ,
        .high_count  (high_count)
`endif
    );

    always #5 inclk0 = ~inclk0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    // Reference model: works on absolute cycle numbers. A c0 rise sampled at
    // edge n shows up as rise_tick after edge n+2; a period is the distance
    // between two consecutive rise_tick cycles.
    int m_cyc = 0;
    int tick_q[$];
    int hi_q[$];
    int mode = 0;          // 0 idle, 1 waiting for first tick, 2 measuring
    int last_rise = 0;
    int good = 0;
    int hi_latest = 0;
    int hi_start = 0;
    bit e_rise = 0, e_pv = 0, e_locked = 0, e_fault = 0;
    int e_pc = 0, e_hc = 0;

    task automatic model_step();
        bit pr;
        bit ok;
        bit tol_ok;
        int per;
        int prev_good;
        int hi_pr;
        m_cyc++;
        pr    = e_rise;
        hi_pr = hi_latest;
        e_pv  = 0;
        if (!reset_n) begin
            while (tick_q.size() > 0 && tick_q[0] <= m_cyc + 2) begin
                void'(tick_q.pop_front());
                void'(hi_q.pop_front());
            end
            e_rise = 0; e_pc = 0; e_hc = 0; e_locked = 0; e_fault = 0;
            good = 0; mode = 0;
            return;
        end
        e_rise = 0;
        if (tick_q.size() > 0 && tick_q[0] == m_cyc) begin
            e_rise = 1;
            void'(tick_q.pop_front());
            hi_latest = hi_q.pop_front();
        end
        prev_good = good;
        if (!enable) begin
            mode = 0; good = 0; e_locked = 0; e_fault = 0;
            return;
        end
        ok = 1;
        case (mode)
            0: mode = 1;
            1: if (pr) begin
                mode = 2; last_rise = m_cyc - 1; hi_start = hi_pr;
            end
            default: begin
                if (pr) begin
                    per = m_cyc - 1 - last_rise;
                    if (per > 65535) per = 65535;
                    e_pc = per;
                    e_pv = 1;
                    e_hc = hi_start;
                    tol_ok = (per - EXP_PERIOD <= TOL) && (EXP_PERIOD - per <= TOL);
`ifdef DIV_MON_DUTY_EN
                    tol_ok = tol_ok && (2 * hi_start - per <= 2 * TOL) && (per - 2 * hi_start <= 2 * TOL);
`endif
                    good = tol_ok ? ((good < LOCK_CNT) ? good + 1 : LOCK_CNT) : 0;
                    last_rise = m_cyc - 1;
                    hi_start = hi_pr;
                end else if (m_cyc - 1 - last_rise == FAULT_TIMEOUT) begin
                    e_fault = 1; good = 0; ok = 0; mode = 1;
                end
            end
        endcase
        e_locked = ok && (prev_good == LOCK_CNT);
    endtask

    task automatic step();
        @(posedge inclk0);
        model_step();
        @(negedge inclk0);
        check("rise_tick", rise_tick, e_rise);
        check("period_valid", period_valid, e_pv);
        check("period_count", period_count, e_pc);
        check("locked", locked, e_locked);
        check("fault", fault, e_fault);
`ifdef DIV_MON_DUTY_EN
        check("high_count", high_count, e_hc);
`endif
    endtask

    task automatic run_period(input int per, input int hi);
        c0 = 1'b1;
        tick_q.push_back(m_cyc + 3);
        hi_q.push_back(hi);
        repeat (hi) step();
        c0 = 1'b0;
        repeat (per - hi) step();
    endtask

    initial begin
        int per;
        @(negedge inclk0);
        repeat (3) step();
        check("rst_locked", locked, 0);
        check("rst_fault", fault, 0);
        check("rst_period_count", period_count, 0);
        reset_n = 1'b1;
        step();
        enable = 1'b1;
        repeat (2) step();

        repeat (6) run_period(128, 64);
        check("lock_after_5_ticks", locked, 1);
        check("nominal_period", period_count, 128);

        run_period(140, 70);
        repeat (5) run_period(128, 64);
        check("relock", locked, 1);

        run_period(124, 62);
        run_period(132, 66);
        run_period(133, 66);
        run_period(128, 64);
        run_period(123, 61);
        for (int i = 0; i < 16; i++) begin
            per = 120 + int'($urandom_range(0, 16));
            run_period(per, per / 2 - 3 + int'($urandom_range(0, 6)));
        end

        repeat (5) run_period(128, 64);
        run_period(FAULT_TIMEOUT, 512);
        check("tie_no_fault", fault, 0);
        run_period(FAULT_TIMEOUT + 1, 512);
        repeat (5) run_period(128, 64);
        check("tie2_fault", fault, 1);

        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (6) run_period(128, 64);
        c0 = 1'b0;
        repeat (1100) step();
        check("missing_clk_fault", fault, 1);
        check("missing_clk_unlock", locked, 0);
        repeat (3) run_period(128, 64);
        check("fault_sticky", fault, 1);
        enable = 1'b0;
        step();
        check("fault_clear_disable", fault, 0);

        run_period(128, 64);
        enable = 1'b1;
        repeat (6) run_period(128, 64);

        c0 = 1'b1;
        tick_q.push_back(m_cyc + 3);
        hi_q.push_back(64);
        repeat (64) step();
        c0 = 1'b0;
        repeat (20) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mid_rst_locked", locked, 0);
        check("mid_rst_period_count", period_count, 0);
        check("mid_rst_valid", period_valid, 0);
        repeat (44) step();
        repeat (3) run_period(128, 64);
        check("post_rst_period", period_count, 128);

`ifdef DIV_MON_DUTY_EN
        repeat (6) run_period(128, 100);
        check("duty_high_count", high_count, 100);
        check("duty_no_lock", locked, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_clk_monitor.md
DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 Parameter EXP_PERIOD, default 128, expected c0 period in inclk0 cycles (50 MHz / 0.39 MHz).
REQ-002 Parameter TOL, default 4, allowed absolute period deviation in inclk0 cycles.
REQ-003 Parameter LOCK_CNT, default 4, consecutive in-tolerance periods required for lock (1..15).
REQ-004 Parameter FAULT_TIMEOUT, default 1024, inclk0 cycles without a c0 rising edge before fault (< 65535).
REQ-005 inclk0  input  1  sole clock, 50 MHz reference.
REQ-006 reset_n  input  1  reset, synchronous to inclk0, active-low.
REQ-007 c0  input  1  divided clock from the upstream divider stage; asynchronous to inclk0.
REQ-008 enable  input  1  monitor enable, synchronous.
REQ-009 rise_tick  output  1  one-cycle pulse per detected c0 rising edge.
REQ-010 period_count  output  16  last measured c0 period in inclk0 cycles.
REQ-011 period_valid  output  1  one-cycle pulse when period_count updates.
REQ-012 locked  output  1  c0 period stable within tolerance.
REQ-013 fault  output  1  sticky missing-clock flag.

Function
REQ-014 c0 SHALL pass through a 2-flop synchronizer plus one history flop; rise_tick SHALL assert for exactly one cycle, registered, 3 inclk0 edges after the first edge that samples c0 high.
REQ-015 States: IDLE (enable=0), ARM (await first rise_tick), MEASURE; any state -> IDLE when enable=0; IDLE -> ARM when enable=1; ARM -> MEASURE on rise_tick, no measurement reported.
REQ-016 In MEASURE a 16-bit counter SHALL clear on the rise_tick cycle and increment each other cycle, saturating at 16'hFFFF.
REQ-017 On rise_tick in MEASURE: period_count <= counter+1 (saturating), period_valid pulses same cycle as registered update; ideal 128-cycle c0 yields 128.
REQ-018 A period is in tolerance when |period_count - EXP_PERIOD| <= TOL.
REQ-019 Each in-tolerance period SHALL increment a good counter (saturating at LOCK_CNT); locked=1 in the cycle after the good counter reaches LOCK_CNT.
REQ-020 An out-of-tolerance period SHALL clear the good counter and drive locked=0 in the cycle after its period_valid.
REQ-021 In MEASURE, if counter reaches FAULT_TIMEOUT-1 with no rise_tick that cycle: fault <= 1, locked <= 0, good counter cleared, state -> ARM.
REQ-022 Simultaneous rise_tick and timeout condition: rise_tick wins, measurement taken, no fault.
REQ-023 fault SHALL remain set until reset_n=0 or enable=0.
REQ-024 Entering IDLE SHALL clear locked, fault, good counter, counter; period_count holds last value.
REQ-025 rise_tick SHALL be generated in all states, including IDLE.

Reset
REQ-026 reset_n=0 at an inclk0 rising edge: state IDLE, all synchronizer flops 0, counter 0, period_count 0, rise_tick 0, period_valid 0, locked 0, fault 0.
REQ-027 Reset mid-measurement SHALL discard the partial period; the first rise_tick after reset never produces period_valid.

Configuration
REQ-028 Macro DIV_MON_DUTY_EN defined: add output high_count [15:0] = synchronized-c0-high cycles in the last period, updated with period_count; in-tolerance additionally requires |2*high_count - period_count| <= 2*TOL.
REQ-029 DIV_MON_DUTY_EN undefined: high_count port and logic absent; tolerance uses REQ-018 only.

Verification
REQ-030 enable=1, c0 period 128, 50% duty -> 2nd rise_tick gives period_count=128 with period_valid; locked=1 one cycle after 5th rise_tick's period_valid.
REQ-031 Locked, then one c0 period of 140 -> period_valid with 140, locked=0 next cycle; relock after 4 further 128-cycle periods.
REQ-032 Locked, c0 held low -> fault=1 and locked=0 after 1024 cycles from last rise_tick; fault persists when c0 resumes, clears on enable=0.
REQ-033 reset_n=0 for one cycle mid-period -> all outputs 0 next cycle; first post-reset rise_tick no period_valid.
REQ-034 DIV_MON_DUTY_EN defined, c0 period 128 high 100 cycles -> high_count=100, period out of tolerance, locked never asserts.
